// File: rtl/pipe_scroll_if.sv
// Control/status bundle between the game-flow sequencer and its host logic.
// master drives the player inputs; slave is the sequencer side.
interface pipe_scroll_if #(
    parameter int OFS_BITS = 5
);
    logic                start;
    logic                collision;
    logic                pause;
    logic [1:0]          state;
    logic                pipes_en;
    logic                shift;
    logic [OFS_BITS-1:0] scroll_ofs;
    logic [7:0]          score;
    logic [1:0]          speed_level;
    logic                rng_rst;

    modport master (
        output start, collision, pause,
        input  state, pipes_en, shift, scroll_ofs, score, speed_level, rng_rst
    );

    modport slave (
        input  start, collision, pause,
        output state, pipes_en, shift, scroll_ofs, score, speed_level, rng_rst
    );
endinterface

// File: rtl/pipe_scroll_ctrl.sv
// Pipe-field game sequencer: scroll tick prescaler, IDLE/COUNTDOWN/RUN/OVER flow,
// slot offset/shift strobe, score and speed level. Optional macro PIPE_SCROLL_RESEED_EN.
module pipe_scroll_ctrl #(
    parameter int TICK_DIV        = 50000,
    parameter int OFS_BITS        = 5,
    parameter int SPEED_STEP      = 8,
    parameter int MAX_LEVEL       = 3,
    parameter int COUNTDOWN_TICKS = 150
) (
    input  logic         clk,
    input  logic         rst,
    pipe_scroll_if.slave bus
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(COUNTDOWN_TICKS + 1);
    localparam int SW = OFS_BITS + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CD   = 2'd1,
        S_RUN  = 2'd2,
        S_OVER = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [CW-1:0]       cd_q, cd_d;
    logic [OFS_BITS-1:0] ofs_q, ofs_d;
    logic [7:0]          score_q, score_d;
    logic [1:0]          lvl_q, lvl_d;
    logic                shift_q, shift_d;

    logic                run_en;
    logic                tick;
    logic [SW-1:0]       sum;
    logic [8:0]          score_inc;
    logic [8:0]          lvl_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            cd_q    <= '0;
            ofs_q   <= '0;
            score_q <= '0;
            lvl_q   <= '0;
            shift_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cd_q    <= cd_d;
            ofs_q   <= ofs_d;
            score_q <= score_d;
            lvl_q   <= lvl_d;
            shift_q <= shift_d;
        end
    end

    // Score+1 is kept at 9 bits so the level keeps saturating once score pins at 255.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        cd_d      = cd_q;
        ofs_d     = ofs_q;
        score_d   = score_q;
        lvl_d     = lvl_q;
        shift_d   = 1'b0;

        run_en    = (state_q == S_CD) || ((state_q == S_RUN) && !bus.pause);
        tick      = run_en && (presc_q == PW'(TICK_DIV - 1));
        sum       = SW'(ofs_q) + SW'(lvl_q) + SW'(1);
        score_inc = {1'b0, score_q} + 9'd1;
        lvl_full  = score_inc / 9'(SPEED_STEP);

        if (run_en) begin
            presc_d = tick ? '0 : PW'(presc_q + 1'b1);
        end

        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                cd_d    = '0;
                ofs_d   = '0;
                score_d = '0;
                lvl_d   = '0;
                if (bus.start) begin
                    state_d = S_CD;
                end
            end
            S_CD: begin
                ofs_d = '0;
                if (tick) begin
                    if (cd_q == CW'(COUNTDOWN_TICKS - 1)) begin
                        state_d = S_RUN;
                        cd_d    = '0;
                    end else begin
                        cd_d = CW'(cd_q + 1'b1);
                    end
                end
            end
            S_RUN: begin
                if (bus.collision) begin
                    // Collision beats a same-cycle carry: nothing advances.
                    state_d = S_OVER;
                    presc_d = presc_q;
                end else if (tick) begin
                    ofs_d = sum[OFS_BITS-1:0];
                    if (sum[OFS_BITS]) begin
                        shift_d = 1'b1;
                        score_d = score_inc[8] ? 8'd255 : score_inc[7:0];
                        lvl_d   = (lvl_full > 9'(MAX_LEVEL)) ? 2'(MAX_LEVEL) : lvl_full[1:0];
                    end
                end
            end
            S_OVER: begin
                if (bus.start) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    cd_d    = '0;
                    ofs_d   = '0;
                    score_d = '0;
                    lvl_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef PIPE_SCROLL_RESEED_EN
    logic rng_q;

    // High during the first COUNTDOWN cycle of every game.
    always_ff @(posedge clk) begin
        if (rst) begin
            rng_q <= 1'b0;
        end else begin
            rng_q <= (state_q == S_IDLE) && bus.start;
        end
    end

    assign bus.rng_rst = rng_q;
`else
    assign bus.rng_rst = 1'b0;
`endif

    assign bus.state       = state_q;
    assign bus.pipes_en    = (state_q == S_RUN);
    assign bus.shift       = shift_q;
    assign bus.scroll_ofs  = ofs_q;
    assign bus.score       = score_q;
    assign bus.speed_level = lvl_q;

endmodule

// File: tb/tb_pipe_scroll_ctrl.sv
// Directed bench for pipe_scroll_ctrl; shift strobes are checked by a scoreboard monitor.
module tb_pipe_scroll_ctrl;
    localparam int TD   = 4;
    localparam int OB   = 3;
    localparam int SS   = 2;
    localparam int ML   = 2;
    localparam int CT   = 2;
    localparam int SLOT = 1 << OB;
`ifdef PIPE_SCROLL_RESEED_EN
    localparam int RS = 1;
`else
    localparam int RS = 0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_scroll_if #(.OFS_BITS(OB)) bus ();

    pipe_scroll_ctrl #(
        .TICK_DIV(TD),
        .OFS_BITS(OB),
        .SPEED_STEP(SS),
        .MAX_LEVEL(ML),
        .COUNTDOWN_TICKS(CT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int ofs;
        int score;
        int lvl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   m_ofs, m_score, m_lvl, m_clears;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference step for one scroll tick in RUN; queues the strobe it should cause.
    task automatic model_tick();
        int s, raw;
        s = m_ofs + m_lvl + 1;
        if (s >= SLOT) begin
            raw      = m_score + 1;
            m_lvl    = (raw / SS > ML) ? ML : raw / SS;
            m_score  = (raw > 255) ? 255 : raw;
            m_clears++;
            sb.push_back('{s - SLOT, m_score, m_lvl});
        end
        m_ofs = s % SLOT;
    endtask

    task automatic tick_wait();
        repeat (TD) @(posedge clk);
        #1;
    endtask

    task automatic step();
        model_tick();
        tick_wait();
        chk("run_ofs", int'(bus.scroll_ofs), m_ofs);
    endtask

    task automatic model_clear();
        m_ofs    = 0;
        m_score  = 0;
        m_lvl    = 0;
        m_clears = 0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.collision = 1'b0;
        bus.pause     = 1'b0;
        model_clear();

        fork
            forever begin
                @(negedge clk);
                if (bus.shift === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_shift: shift=1 state=%0d ofs=%0d, expected no shift",
                                 bus.state, bus.scroll_ofs);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("shift_ofs", int'(bus.scroll_ofs), mon_e.ofs);
                        chk("shift_score", int'(bus.score), mon_e.score);
                        chk("shift_lvl", int'(bus.speed_level), mon_e.lvl);
                        chk("shift_state", int'(bus.state), 2);
                    end
                end
            end
        join_none

        // Reset and idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_state", int'(bus.state), 0);
        chk("rst_score", int'(bus.score), 0);
        chk("rst_ofs", int'(bus.scroll_ofs), 0);
        chk("rst_lvl", int'(bus.speed_level), 0);
        chk("rst_rng", int'(bus.rng_rst), 0);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("idle_state", int'(bus.state), 0);
            chk("idle_pipes_en", int'(bus.pipes_en), 0);
        end
        chk("idle_score", int'(bus.score), 0);
        chk("idle_ofs", int'(bus.scroll_ofs), 0);

        // Start pulse and countdown
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("cd_state", int'(bus.state), 1);
        chk("cd_rng_first", int'(bus.rng_rst), RS);
        chk("cd_pipes_en", int'(bus.pipes_en), 0);
        @(posedge clk);
        #1 chk("cd_rng_second", int'(bus.rng_rst), 0);
        repeat (6) @(posedge clk);
        #1 chk("cd_state_late", int'(bus.state), 1);
        @(posedge clk);
        #1 chk("run_entry_state", int'(bus.state), 2);
        chk("run_pipes_en", int'(bus.pipes_en), 1);
        chk("run_entry_ofs", int'(bus.scroll_ofs), 0);

        // Level 0: one pixel per tick, first slot clear after 8 ticks
        model_clear();
        for (int i = 0; i < 8; i++) begin
            model_tick();
            tick_wait();
            chk("lvl0_ofs", int'(bus.scroll_ofs), (i + 1) % 8);
        end
        chk("lvl0_score", int'(bus.score), 1);
        chk("lvl0_lvl", int'(bus.speed_level), 0);

        // Speed ramp
        repeat (8) step();
        chk("ramp_score2", int'(bus.score), 2);
        chk("ramp_lvl1", int'(bus.speed_level), 1);
        repeat (8) step();
        chk("ramp_score4", int'(bus.score), 4);
        chk("ramp_lvl2", int'(bus.speed_level), 2);
        repeat (2) step();
        chk("ramp_ofs6", int'(bus.scroll_ofs), 6);
        step();
        chk("ramp_wrap_ofs", int'(bus.scroll_ofs), 1);
        chk("ramp_wrap_score", int'(bus.score), 5);
        step();

        // Pause mid-slot for 20 clocks
        repeat (2) @(posedge clk);
        #1 bus.pause = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("pause_ofs", int'(bus.scroll_ofs), 4);
        chk("pause_state", int'(bus.state), 2);
        bus.pause = 1'b0;
        @(posedge clk);
        #1 chk("pause_resume_ofs", int'(bus.scroll_ofs), 4);
        model_tick();
        @(posedge clk);
        #1 chk("pause_tick_ofs", int'(bus.scroll_ofs), 7);

        // Collision on the tick that would carry (7+3)
        repeat (3) @(posedge clk);
        #1 bus.collision = 1'b1;
        @(posedge clk);
        #1 bus.collision = 1'b0;
        chk("over_state", int'(bus.state), 3);
        chk("over_score", int'(bus.score), 5);
        chk("over_ofs", int'(bus.scroll_ofs), 7);
        chk("over_pipes_en", int'(bus.pipes_en), 0);
        repeat (6) @(posedge clk);
        #1 chk("over_hold_state", int'(bus.state), 3);
        chk("over_hold_lvl", int'(bus.speed_level), 2);

        // Held start: OVER -> IDLE -> COUNTDOWN
        bus.start = 1'b1;
        @(posedge clk);
        #1 chk("restart_idle", int'(bus.state), 0);
        chk("restart_score", int'(bus.score), 0);
        chk("restart_lvl", int'(bus.speed_level), 0);
        chk("restart_ofs", int'(bus.scroll_ofs), 0);
        @(posedge clk);
        #1 chk("restart_cd", int'(bus.state), 1);
        chk("restart_rng", int'(bus.rng_rst), RS);
        @(posedge clk);
        #1 chk("restart_rng_off", int'(bus.rng_rst), 0);
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("restart_cd_late", int'(bus.state), 1);
        @(posedge clk);
        #1 chk("restart_run", int'(bus.state), 2);

        // Saturation: 260 slot clears
        model_clear();
        while (m_clears < 260) step();
        chk("sat_score", int'(bus.score), 255);
        chk("sat_lvl", int'(bus.speed_level), 2);

        // Reset beats start
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1 chk("rst_run_state", int'(bus.state), 0);
        chk("rst_run_score", int'(bus.score), 0);
        chk("rst_run_lvl", int'(bus.speed_level), 0);
        chk("rst_run_shift", int'(bus.shift), 0);
        @(posedge clk);
        #1 chk("rst_start_state", int'(bus.state), 0);
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_scroll_ctrl.md
Name: pipe_scroll_ctrl

Overview:
Game-flow sequencer for the pipe field. It divides clk into scroll ticks and runs the IDLE/COUNTDOWN/RUN/OVER state machine. It advances a horizontal scroll offset within one pipe slot and issues a one-cycle shift strobe each time the offset wraps; that strobe drives the pipe shift register's enable. It also keeps the score and a speed level that raises the scroll step as pipes are cleared.

Parameters:
TICK_DIV, 50000, clk cycles per scroll tick (>=2)
OFS_BITS, 5, scroll offset width; slot width = 2^OFS_BITS pixels
SPEED_STEP, 8, pipes cleared per speed level increase
MAX_LEVEL, 3, saturation value of speed_level (<=3)
COUNTDOWN_TICKS, 150, ticks spent in COUNTDOWN before RUN (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  level; sampled each clk
collision  in  1  bird/pipe hit, level
pause  in  1  level; freezes scrolling while high in RUN
state  out  2  0=IDLE 1=COUNTDOWN 2=RUN 3=OVER
pipes_en  out  1  high while state==RUN
shift  out  1  one-cycle strobe: pipe field advances one slot
scroll_ofs  out  OFS_BITS  pixel offset inside current slot
score  out  8  pipes cleared, saturating
speed_level  out  2  current speed level
rng_rst  out  1  RNG reseed pulse (see Optional Feature)

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; prescaler, countdown counter, scroll_ofs, score and speed_level =0; shift=0; rng_rst=0. Reset wins over every other input.
- Prescaler counts 0..TICK_DIV-1. Internal tick=1 for the one cycle in which the count equals TICK_DIV-1; the count then wraps to 0.
- Prescaler runs only in COUNTDOWN, and in RUN with pause=0. It holds its value while paused. It is cleared on entry to COUNTDOWN.
- IDLE: all counters held at 0. start=1 -> COUNTDOWN on the next edge.
- COUNTDOWN: counts ticks. On the COUNTDOWN_TICKS-th tick -> RUN; the prescaler and scroll_ofs are 0 on entry to RUN.
- RUN, on each tick with collision=0:
  - sum = scroll_ofs + speed_level + 1, computed at OFS_BITS+1 bits.
  - scroll_ofs <= sum mod 2^OFS_BITS.
  - If sum >= 2^OFS_BITS, shift=1 on the next cycle only.
  - Also on carry: score <= min(score+1, 255); speed_level <= min((score+1)/SPEED_STEP, MAX_LEVEL).
- RUN, collision=1: -> OVER on the next edge regardless of tick or pause. That cycle produces no shift and no score or offset update; collision has priority over a simultaneous carry.
- OVER: scroll frozen; score and speed_level held for display. start=1 -> IDLE with score, speed_level and scroll_ofs cleared. start must be re-sampled in IDLE to begin a new game, so a held start takes two edges to reach COUNTDOWN.
- shift is never asserted outside RUN. At most one shift per tick.
- pipes_en is combinational from state. All other outputs are registered.
- start is ignored in COUNTDOWN and RUN. pause is ignored outside RUN.

Optional Feature:
Macro PIPE_SCROLL_RESEED_EN.
- Defined: rng_rst=1 for exactly one cycle, the first cycle in COUNTDOWN, so each game reseeds the pipe RNG.
- Undefined: rng_rst is tied 0 and the pipe RNG free-runs across games.

Test Plan:
Bench parameters: TICK_DIV=4, OFS_BITS=3, SPEED_STEP=2, MAX_LEVEL=2, COUNTDOWN_TICKS=2.
- Reset/idle: rst high 2 cycles, then idle 10 cycles -> state=0, shift never 1, score=0, scroll_ofs=0, pipes_en=0.
- Start/countdown: start pulse in IDLE -> state=1 next edge; state=2 exactly 8 clocks later; with PIPE_SCROLL_RESEED_EN, rng_rst=1 on the first COUNTDOWN cycle only.
- Level 0 scroll: in RUN -> scroll_ofs 1,2,...,7,0 on successive ticks; shift=1 one cycle after the 8th tick (32 clocks after RUN entry); score=1.
- Speed ramp: continue -> after score=2, speed_level=1 and shift every 4 ticks; after score=4, speed_level=2 and offset 6+3 wraps to 1 with shift.
- Pause/collision: pause high 20 clocks mid-slot -> scroll_ofs and prescaler frozen, no shift. Then collision on a carry tick -> state=3, no shift, score unchanged; start -> state=0, score=0.
- Saturation: force 260 slot clears -> score stays 255, speed_level stays 2.
